// File: rtl/ooo_pkg.sv
// Shared out-of-order core types: load/store issue-queue entry and ROB age compare.
package ooo_pkg;

    localparam int LSIQ_DATA_WIDTH = 32;
    localparam int LSIQ_ROB_WIDTH  = 4;
    localparam int LSIQ_PREG_WIDTH = 7;

    typedef struct packed {
        logic                       valid;
        logic                       memwrite;
        logic [3:0]                 alu_op;
        logic [LSIQ_DATA_WIDTH-1:0] imm;
        logic [LSIQ_PREG_WIDTH-1:0] prs1;
        logic [LSIQ_PREG_WIDTH-1:0] prs2;
        logic                       rdy1;
        logic                       rdy2;
        logic [LSIQ_DATA_WIDTH-1:0] val1;
        logic [LSIQ_DATA_WIDTH-1:0] val2;
        logic [LSIQ_PREG_WIDTH-1:0] prd;
        logic [LSIQ_ROB_WIDTH-1:0]  rob_tag;
    } lsiq_entry_t;

    // Tags are compared on a ring: tag is younger when it lies in the half-window after ref_tag.
    function automatic logic is_younger(input logic [LSIQ_ROB_WIDTH-1:0] tag,
                                        input logic [LSIQ_ROB_WIDTH-1:0] ref_tag);
        logic [LSIQ_ROB_WIDTH-1:0] d;
        d = tag - ref_tag;
        return (d != '0) && !d[LSIQ_ROB_WIDTH-1];
    endfunction

endpackage

// File: rtl/ls_issue_queue_if.sv
// Dispatch, CDB, branch-recovery and LSU issue signals of the load/store issue queue.
interface ls_issue_queue_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ROB_WIDTH  = 4,
    parameter int PREG_WIDTH = 7
);
    logic                  i_disp_valid;
    logic                  o_disp_ready;
    logic                  i_disp_memwrite;
    logic [3:0]            i_disp_alu_op;
    logic [DATA_WIDTH-1:0] i_disp_imm;
    logic [PREG_WIDTH-1:0] i_disp_prs1;
    logic [PREG_WIDTH-1:0] i_disp_prs2;
    logic                  i_disp_rs1_rdy;
    logic                  i_disp_rs2_rdy;
    logic [DATA_WIDTH-1:0] i_disp_rs1_val;
    logic [DATA_WIDTH-1:0] i_disp_rs2_val;
    logic [PREG_WIDTH-1:0] i_disp_prd;
    logic [ROB_WIDTH-1:0]  i_disp_rob_tag;

    logic                  i_cdb_valid;
    logic [PREG_WIDTH-1:0] i_cdb_prd;
    logic [DATA_WIDTH-1:0] i_cdb_data;

    logic                  o_valid;
    logic                  i_lsu_ready;
    logic [DATA_WIDTH-1:0] o_base_addr;
    logic [DATA_WIDTH-1:0] o_offset;
    logic [DATA_WIDTH-1:0] o_store_data;
    logic                  o_memwrite;
    logic [3:0]            o_alu_op;
    logic [PREG_WIDTH-1:0] o_prd;
    logic [ROB_WIDTH-1:0]  o_rob_tag;

    logic                  branch_mispredict;
    logic [ROB_WIDTH-1:0]  branch_rob_tag;

    modport master (
        output i_disp_valid, i_disp_memwrite, i_disp_alu_op, i_disp_imm,
               i_disp_prs1, i_disp_prs2, i_disp_rs1_rdy, i_disp_rs2_rdy,
               i_disp_rs1_val, i_disp_rs2_val, i_disp_prd, i_disp_rob_tag,
               i_cdb_valid, i_cdb_prd, i_cdb_data, i_lsu_ready,
               branch_mispredict, branch_rob_tag,
        input  o_disp_ready, o_valid, o_base_addr, o_offset, o_store_data,
               o_memwrite, o_alu_op, o_prd, o_rob_tag
    );

    modport slave (
        input  i_disp_valid, i_disp_memwrite, i_disp_alu_op, i_disp_imm,
               i_disp_prs1, i_disp_prs2, i_disp_rs1_rdy, i_disp_rs2_rdy,
               i_disp_rs1_val, i_disp_rs2_val, i_disp_prd, i_disp_rob_tag,
               i_cdb_valid, i_cdb_prd, i_cdb_data, i_lsu_ready,
               branch_mispredict, branch_rob_tag,
        output o_disp_ready, o_valid, o_base_addr, o_offset, o_store_data,
               o_memwrite, o_alu_op, o_prd, o_rob_tag
    );
endinterface

// File: rtl/ls_issue_queue_wakeup.sv
// Combinational source-operand capture: a not-ready source whose tag matches the CDB takes its value.
module lsiq_wakeup #(
    parameter int DATA_WIDTH = 32,
    parameter int PREG_WIDTH = 7
) (
    input  logic                  src_rdy,
    input  logic [DATA_WIDTH-1:0] src_val,
    input  logic [PREG_WIDTH-1:0] src_tag,
    input  logic                  cdb_valid,
    input  logic [PREG_WIDTH-1:0] cdb_prd,
    input  logic [DATA_WIDTH-1:0] cdb_data,
    output logic                  rdy_out,
    output logic [DATA_WIDTH-1:0] val_out
);
    logic hit;

    assign hit     = cdb_valid && !src_rdy && (src_tag == cdb_prd);
    assign rdy_out = src_rdy || hit;
    assign val_out = hit ? cdb_data : src_val;
endmodule

// File: rtl/ls_issue_queue.sv
// In-order load/store issue queue: buffers memory ops, captures operands from the CDB,
// issues the oldest ready op to the LSU and squashes ops younger than a mispredicted branch.
module ls_issue_queue
    import ooo_pkg::*;
#(
    parameter int DATA_WIDTH = LSIQ_DATA_WIDTH,
    parameter int ROB_WIDTH  = LSIQ_ROB_WIDTH,
    parameter int PREG_WIDTH = LSIQ_PREG_WIDTH,
    parameter int DEPTH      = 8
) (
    input  logic              clk,
    input  logic              reset,
    ls_issue_queue_if.slave   bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;
    lsiq_entry_t      entries [DEPTH];

    logic [DEPTH-1:0]      wk_rdy1;
    logic [DEPTH-1:0]      wk_rdy2;
    logic [DATA_WIDTH-1:0] wk_val1 [DEPTH];
    logic [DATA_WIDTH-1:0] wk_val2 [DEPTH];

    logic                  disp_rdy1;
    logic                  disp_rdy2;
    logic [DATA_WIDTH-1:0] disp_val1;
    logic [DATA_WIDTH-1:0] disp_val2;
    lsiq_entry_t           disp_entry;

    logic             head_younger;
    logic             disp_fire;
    logic             issue_fire;
    logic             flush;
    logic [DEPTH-1:0] younger;
    logic [CNT_W-1:0] n_old;

    // Stored sources snoop the CDB every cycle; only live entries latch the result.
    for (genvar g = 0; g < DEPTH; g++) begin : g_entry
        lsiq_wakeup #(.DATA_WIDTH(DATA_WIDTH), .PREG_WIDTH(PREG_WIDTH)) u_wk1 (
            .src_rdy  (entries[g].rdy1),
            .src_val  (entries[g].val1),
            .src_tag  (entries[g].prs1),
            .cdb_valid(bus.i_cdb_valid),
            .cdb_prd  (bus.i_cdb_prd),
            .cdb_data (bus.i_cdb_data),
            .rdy_out  (wk_rdy1[g]),
            .val_out  (wk_val1[g])
        );
        lsiq_wakeup #(.DATA_WIDTH(DATA_WIDTH), .PREG_WIDTH(PREG_WIDTH)) u_wk2 (
            .src_rdy  (entries[g].rdy2),
            .src_val  (entries[g].val2),
            .src_tag  (entries[g].prs2),
            .cdb_valid(bus.i_cdb_valid),
            .cdb_prd  (bus.i_cdb_prd),
            .cdb_data (bus.i_cdb_data),
            .rdy_out  (wk_rdy2[g]),
            .val_out  (wk_val2[g])
        );
    end

    // Same compare on the incoming op gives the dispatch-cycle bypass; loads never wait on rs2.
    lsiq_wakeup #(.DATA_WIDTH(DATA_WIDTH), .PREG_WIDTH(PREG_WIDTH)) u_disp_wk1 (
        .src_rdy  (bus.i_disp_rs1_rdy),
        .src_val  (bus.i_disp_rs1_val),
        .src_tag  (bus.i_disp_prs1),
        .cdb_valid(bus.i_cdb_valid),
        .cdb_prd  (bus.i_cdb_prd),
        .cdb_data (bus.i_cdb_data),
        .rdy_out  (disp_rdy1),
        .val_out  (disp_val1)
    );
    lsiq_wakeup #(.DATA_WIDTH(DATA_WIDTH), .PREG_WIDTH(PREG_WIDTH)) u_disp_wk2 (
        .src_rdy  (bus.i_disp_rs2_rdy || !bus.i_disp_memwrite),
        .src_val  (bus.i_disp_rs2_val),
        .src_tag  (bus.i_disp_prs2),
        .cdb_valid(bus.i_cdb_valid),
        .cdb_prd  (bus.i_cdb_prd),
        .cdb_data (bus.i_cdb_data),
        .rdy_out  (disp_rdy2),
        .val_out  (disp_val2)
    );

    always_comb begin
        disp_entry          = '0;
        disp_entry.valid    = 1'b1;
        disp_entry.memwrite = bus.i_disp_memwrite;
        disp_entry.alu_op   = bus.i_disp_alu_op;
        disp_entry.imm      = bus.i_disp_imm;
        disp_entry.prs1     = bus.i_disp_prs1;
        disp_entry.prs2     = bus.i_disp_prs2;
        disp_entry.rdy1     = disp_rdy1;
        disp_entry.rdy2     = disp_rdy2;
        disp_entry.val1     = disp_val1;
        disp_entry.val2     = disp_val2;
        disp_entry.prd      = bus.i_disp_prd;
        disp_entry.rob_tag  = bus.i_disp_rob_tag;
    end

    // Younger entries sit contiguously at the tail, so the survivors are simply the older ones.
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        younger = '0;
        n_old   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entries[i].valid) begin
                if (is_younger(entries[i].rob_tag, bus.branch_rob_tag))
                    younger[i] = 1'b1;
                else
                    n_old = n_old + CNT_W'(1);
            end
        end
    end

    assign head_younger     = is_younger(entries[head].rob_tag, bus.branch_rob_tag);
    assign flush            = bus.branch_mispredict;
    assign bus.o_disp_ready = (count < CNT_W'(DEPTH));
    assign bus.o_valid      = (count != '0) && entries[head].rdy1 && entries[head].rdy2 &&
                              !(flush && head_younger);
    assign disp_fire        = bus.i_disp_valid && bus.o_disp_ready;
    assign issue_fire       = bus.o_valid && bus.i_lsu_ready;

    assign bus.o_base_addr  = entries[head].val1;
    assign bus.o_offset     = entries[head].imm;
    assign bus.o_store_data = entries[head].val2;
    assign bus.o_memwrite   = entries[head].memwrite;
    assign bus.o_alu_op     = entries[head].alu_op;
    assign bus.o_prd        = entries[head].prd;
    assign bus.o_rob_tag    = entries[head].rob_tag;

    // NOTE: sequential state uses non-blocking assignments only, so later writes in this
    // block (dispatch, issue, flush) override earlier ones on the same entry without ordering hazards.
    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            // NOTE: the entry array is reset as a whole so the head-driven outputs read zero after reset.
            for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (entries[i].valid) begin
                    entries[i].rdy1 <= wk_rdy1[i];
                    entries[i].val1 <= wk_val1[i];
                    entries[i].rdy2 <= wk_rdy2[i];
                    entries[i].val2 <= wk_val2[i];
                end
            end

            if (flush) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (younger[i]) entries[i].valid <= 1'b0;
                end
                tail  <= head + n_old[PTR_W-1:0];
                count <= n_old - CNT_W'(issue_fire);
            end else begin
                if (disp_fire) begin
                    entries[tail] <= disp_entry;
                    tail          <= tail + PTR_W'(1);
                end
                count <= count + CNT_W'(disp_fire) - CNT_W'(issue_fire);
            end

            if (issue_fire) begin
                entries[head].valid <= 1'b0;
                head                <= head + PTR_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_ls_issue_queue.sv
// Directed self-checking bench for ls_issue_queue: one task per scenario, inline comparisons.
module tb_ls_issue_queue;
    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    ls_issue_queue_if #(.DATA_WIDTH(32), .ROB_WIDTH(4), .PREG_WIDTH(7)) bus ();

    ls_issue_queue #(.DATA_WIDTH(32), .ROB_WIDTH(4), .PREG_WIDTH(7), .DEPTH(8)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_disp(input logic mw, input logic [6:0] prs1, input logic rdy1,
                            input logic [31:0] val1, input logic [6:0] prs2, input logic rdy2,
                            input logic [31:0] val2, input logic [31:0] imm,
                            input logic [3:0] rob, input logic [6:0] prd);
        bus.i_disp_valid    = 1'b1;
        bus.i_disp_memwrite = mw;
        bus.i_disp_alu_op   = 4'h2;
        bus.i_disp_prs1     = prs1;
        bus.i_disp_rs1_rdy  = rdy1;
        bus.i_disp_rs1_val  = val1;
        bus.i_disp_prs2     = prs2;
        bus.i_disp_rs2_rdy  = rdy2;
        bus.i_disp_rs2_val  = val2;
        bus.i_disp_imm      = imm;
        bus.i_disp_rob_tag  = rob;
        bus.i_disp_prd      = prd;
    endtask

    task automatic idle_inputs();
        bus.i_disp_valid      = 1'b0;
        bus.i_cdb_valid       = 1'b0;
        bus.branch_mispredict = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        set_disp(1'b0, 7'd0, 1'b0, 32'h0, 7'd0, 1'b0, 32'h0, 32'h0, 4'd0, 7'd0);
        bus.i_disp_valid   = 1'b0;
        bus.i_cdb_prd      = '0;
        bus.i_cdb_data     = '0;
        bus.i_lsu_ready    = 1'b0;
        bus.branch_rob_tag = '0;
        step();
        step();
        reset = 1'b0;
        #1;
        checks++; if (bus.o_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b exp 0", bus.o_valid); end
        checks++; if (bus.o_disp_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b exp 1", bus.o_disp_ready); end
        checks++; if (bus.o_base_addr !== 32'h0 || bus.o_store_data !== 32'h0 || bus.o_offset !== 32'h0)
            begin failures++; $display("FAIL reset_data: got %h/%h/%h exp 0", bus.o_base_addr, bus.o_store_data, bus.o_offset); end
        checks++; if (bus.o_rob_tag !== 4'h0 || bus.o_prd !== 7'h0) begin failures++; $display("FAIL reset_tags: got %h/%h exp 0", bus.o_rob_tag, bus.o_prd); end
    endtask

    task automatic test_load_issue();
        bus.i_lsu_ready = 1'b1;
        set_disp(1'b0, 7'd1, 1'b1, 32'h100, 7'd2, 1'b0, 32'h0, 32'd4, 4'd3, 7'd5);
        #1;
        checks++; if (bus.o_valid !== 1'b0) begin failures++; $display("FAIL load_empty_invisible: got %b exp 0", bus.o_valid); end
        step();
        bus.i_disp_valid = 1'b0;
        #1;
        checks++; if (bus.o_valid !== 1'b1) begin failures++; $display("FAIL load_valid: got %b exp 1", bus.o_valid); end
        checks++; if (bus.o_base_addr !== 32'h100 || bus.o_offset !== 32'd4)
            begin failures++; $display("FAIL load_addr: got %h+%h exp 100+4", bus.o_base_addr, bus.o_offset); end
        checks++; if (bus.o_memwrite !== 1'b0 || bus.o_rob_tag !== 4'd3 || bus.o_prd !== 7'd5 || bus.o_alu_op !== 4'h2)
            begin failures++; $display("FAIL load_fields: got mw=%b rob=%0d prd=%0d op=%h exp 0/3/5/2", bus.o_memwrite, bus.o_rob_tag, bus.o_prd, bus.o_alu_op); end
        step();
        checks++; if (bus.o_valid !== 1'b0 || bus.o_disp_ready !== 1'b1)
            begin failures++; $display("FAIL load_drained: got valid=%b ready=%b exp 0/1", bus.o_valid, bus.o_disp_ready); end
    endtask

    task automatic test_store_wakeup();
        bus.i_lsu_ready = 1'b1;
        set_disp(1'b1, 7'd3, 1'b1, 32'h200, 7'd9, 1'b0, 32'h0, 32'd8, 4'd4, 7'd0);
        step();
        bus.i_disp_valid = 1'b0;
        #1;
        checks++; if (bus.o_valid !== 1'b0) begin failures++; $display("FAIL store_wait1: got %b exp 0", bus.o_valid); end
        step();
        bus.i_cdb_valid = 1'b1;
        bus.i_cdb_prd   = 7'd9;
        bus.i_cdb_data  = 32'hDEADBEEF;
        #1;
        checks++; if (bus.o_valid !== 1'b0) begin failures++; $display("FAIL store_no_same_cycle: got %b exp 0", bus.o_valid); end
        step();
        bus.i_cdb_valid = 1'b0;
        #1;
        checks++; if (bus.o_valid !== 1'b1 || bus.o_store_data !== 32'hDEADBEEF || bus.o_memwrite !== 1'b1)
            begin failures++; $display("FAIL store_woken: got valid=%b data=%h mw=%b exp 1/deadbeef/1", bus.o_valid, bus.o_store_data, bus.o_memwrite); end
        step();
        checks++; if (bus.o_valid !== 1'b0) begin failures++; $display("FAIL store_drained: got %b exp 0", bus.o_valid); end
    endtask

    task automatic test_full_wrap();
        bus.i_lsu_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            set_disp(1'b0, 7'd1, 1'b1, 32'h1000 + i, 7'd0, 1'b0, 32'h0, 32'h0, 4'(i), 7'(i));
            #1;
            checks++; if (bus.o_disp_ready !== 1'b1) begin failures++; $display("FAIL fill_ready_%0d: got %b exp 1", i, bus.o_disp_ready); end
            step();
        end
        set_disp(1'b0, 7'd1, 1'b1, 32'h1008, 7'd0, 1'b0, 32'h0, 32'h0, 4'd9, 7'd9);
        #1;
        checks++; if (bus.o_disp_ready !== 1'b0 || bus.o_valid !== 1'b1 || bus.o_base_addr !== 32'h1000)
            begin failures++; $display("FAIL full_state: got ready=%b valid=%b base=%h exp 0/1/1000", bus.o_disp_ready, bus.o_valid, bus.o_base_addr); end
        bus.i_lsu_ready = 1'b1;
        #1;
        checks++; if (bus.o_disp_ready !== 1'b0) begin failures++; $display("FAIL full_issue_same_cycle: got %b exp 0", bus.o_disp_ready); end
        step();
        bus.i_lsu_ready = 1'b0;
        #1;
        checks++; if (bus.o_disp_ready !== 1'b1 || bus.o_base_addr !== 32'h1001)
            begin failures++; $display("FAIL full_freed: got ready=%b base=%h exp 1/1001", bus.o_disp_ready, bus.o_base_addr); end
        step();
        bus.i_disp_valid = 1'b0;
        #1;
        checks++; if (bus.o_disp_ready !== 1'b0) begin failures++; $display("FAIL refill_full: got %b exp 0", bus.o_disp_ready); end
        bus.i_lsu_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            checks++; if (bus.o_valid !== 1'b1 || bus.o_base_addr !== 32'h1001 + k)
                begin failures++; $display("FAIL drain_%0d: got valid=%b base=%h exp 1/%h", k, bus.o_valid, bus.o_base_addr, 32'h1001 + k); end
            step();
        end
        checks++; if (bus.o_valid !== 1'b0 || bus.o_disp_ready !== 1'b1)
            begin failures++; $display("FAIL drain_empty: got valid=%b ready=%b exp 0/1", bus.o_valid, bus.o_disp_ready); end
    endtask

    task automatic test_in_order();
        bus.i_lsu_ready = 1'b1;
        set_disp(1'b0, 7'd20, 1'b0, 32'h0, 7'd0, 1'b0, 32'h0, 32'h0, 4'd10, 7'd1);
        step();
        set_disp(1'b0, 7'd21, 1'b1, 32'h300, 7'd0, 1'b0, 32'h0, 32'h0, 4'd11, 7'd2);
        step();
        bus.i_disp_valid = 1'b0;
        #1;
        checks++; if (bus.o_valid !== 1'b0 || bus.o_rob_tag !== 4'd10)
            begin failures++; $display("FAIL inorder_blocked: got valid=%b rob=%0d exp 0/10", bus.o_valid, bus.o_rob_tag); end
        step();
        bus.i_cdb_valid = 1'b1;
        bus.i_cdb_prd   = 7'd20;
        bus.i_cdb_data  = 32'h400;
        #1;
        checks++; if (bus.o_valid !== 1'b0) begin failures++; $display("FAIL inorder_still_blocked: got %b exp 0", bus.o_valid); end
        step();
        bus.i_cdb_valid = 1'b0;
        #1;
        checks++; if (bus.o_valid !== 1'b1 || bus.o_rob_tag !== 4'd10 || bus.o_base_addr !== 32'h400)
            begin failures++; $display("FAIL inorder_head: got valid=%b rob=%0d base=%h exp 1/10/400", bus.o_valid, bus.o_rob_tag, bus.o_base_addr); end
        step();
        checks++; if (bus.o_valid !== 1'b1 || bus.o_rob_tag !== 4'd11 || bus.o_base_addr !== 32'h300)
            begin failures++; $display("FAIL inorder_second: got valid=%b rob=%0d base=%h exp 1/11/300", bus.o_valid, bus.o_rob_tag, bus.o_base_addr); end
        step();
        checks++; if (bus.o_valid !== 1'b0) begin failures++; $display("FAIL inorder_drained: got %b exp 0", bus.o_valid); end
    endtask

    task automatic test_flush();
        bus.i_lsu_ready = 1'b0;
        set_disp(1'b0, 7'd1, 1'b1, 32'h505, 7'd0, 1'b0, 32'h0, 32'h0, 4'd5, 7'd5);
        step();
        set_disp(1'b0, 7'd30, 1'b0, 32'h0, 7'd0, 1'b0, 32'h0, 32'h0, 4'd6, 7'd6);
        step();
        set_disp(1'b0, 7'd1, 1'b1, 32'h507, 7'd0, 1'b0, 32'h0, 32'h0, 4'd7, 7'd7);
        step();
        set_disp(1'b0, 7'd1, 1'b1, 32'h508, 7'd0, 1'b0, 32'h0, 32'h0, 4'd8, 7'd8);
        step();
        // Mispredict, CDB wakeup of a survivor and a doomed dispatch all in one cycle.
        set_disp(1'b0, 7'd1, 1'b1, 32'h509, 7'd0, 1'b0, 32'h0, 32'h0, 4'd9, 7'd9);
        bus.branch_mispredict = 1'b1;
        bus.branch_rob_tag    = 4'd6;
        bus.i_cdb_valid       = 1'b1;
        bus.i_cdb_prd         = 7'd30;
        bus.i_cdb_data        = 32'h666;
        #1;
        checks++; if (bus.o_valid !== 1'b1 || bus.o_rob_tag !== 4'd5)
            begin failures++; $display("FAIL flush_older_head: got valid=%b rob=%0d exp 1/5", bus.o_valid, bus.o_rob_tag); end
        step();
        idle_inputs();
        bus.i_lsu_ready = 1'b1;
        #1;
        checks++; if (bus.o_valid !== 1'b1 || bus.o_rob_tag !== 4'd5 || bus.o_base_addr !== 32'h505)
            begin failures++; $display("FAIL flush_keep5: got valid=%b rob=%0d base=%h exp 1/5/505", bus.o_valid, bus.o_rob_tag, bus.o_base_addr); end
        step();
        checks++; if (bus.o_valid !== 1'b1 || bus.o_rob_tag !== 4'd6 || bus.o_base_addr !== 32'h666)
            begin failures++; $display("FAIL flush_keep6_woken: got valid=%b rob=%0d base=%h exp 1/6/666", bus.o_valid, bus.o_rob_tag, bus.o_base_addr); end
        step();
        checks++; if (bus.o_valid !== 1'b0 || bus.o_disp_ready !== 1'b1)
            begin failures++; $display("FAIL flush_removed: got valid=%b ready=%b exp 0/1", bus.o_valid, bus.o_disp_ready); end
    endtask

    task automatic test_flush_wrap();
        bus.i_lsu_ready = 1'b0;
        set_disp(1'b0, 7'd1, 1'b1, 32'h70E, 7'd0, 1'b0, 32'h0, 32'h0, 4'd14, 7'd14);
        step();
        set_disp(1'b0, 7'd1, 1'b1, 32'h70F, 7'd0, 1'b0, 32'h0, 32'h0, 4'd15, 7'd15);
        step();
        set_disp(1'b0, 7'd1, 1'b1, 32'h700, 7'd0, 1'b0, 32'h0, 32'h0, 4'd0, 7'd16);
        step();
        bus.i_disp_valid      = 1'b0;
        bus.branch_mispredict = 1'b1;
        bus.branch_rob_tag    = 4'd15;
        bus.i_lsu_ready       = 1'b1;
        #1;
        checks++; if (bus.o_valid !== 1'b1 || bus.o_rob_tag !== 4'd14)
            begin failures++; $display("FAIL wrap_head14: got valid=%b rob=%0d exp 1/14", bus.o_valid, bus.o_rob_tag); end
        step();
        bus.branch_mispredict = 1'b0;
        #1;
        checks++; if (bus.o_valid !== 1'b1 || bus.o_rob_tag !== 4'd15)
            begin failures++; $display("FAIL wrap_keep15: got valid=%b rob=%0d exp 1/15", bus.o_valid, bus.o_rob_tag); end
        step();
        checks++; if (bus.o_valid !== 1'b0) begin failures++; $display("FAIL wrap_removed0: got %b exp 0", bus.o_valid); end
        // A younger head must not be offered while its squash is pending.
        bus.i_lsu_ready = 1'b0;
        set_disp(1'b0, 7'd1, 1'b1, 32'h701, 7'd0, 1'b0, 32'h0, 32'h0, 4'd1, 7'd17);
        step();
        bus.i_disp_valid      = 1'b0;
        bus.branch_mispredict = 1'b1;
        bus.branch_rob_tag    = 4'd0;
        bus.i_lsu_ready       = 1'b1;
        #1;
        checks++; if (bus.o_valid !== 1'b0) begin failures++; $display("FAIL suppress_younger_head: got %b exp 0", bus.o_valid); end
        step();
        bus.branch_mispredict = 1'b0;
        #1;
        checks++; if (bus.o_valid !== 1'b0 || bus.o_disp_ready !== 1'b1)
            begin failures++; $display("FAIL suppress_removed: got valid=%b ready=%b exp 0/1", bus.o_valid, bus.o_disp_ready); end
    endtask

    task automatic test_disp_bypass();
        bus.i_lsu_ready = 1'b1;
        set_disp(1'b0, 7'd40, 1'b0, 32'h0, 7'd50, 1'b0, 32'h0, 32'd12, 4'd2, 7'd3);
        bus.i_cdb_valid = 1'b1;
        bus.i_cdb_prd   = 7'd40;
        bus.i_cdb_data  = 32'hABC;
        step();
        idle_inputs();
        #1;
        checks++; if (bus.o_valid !== 1'b1 || bus.o_base_addr !== 32'hABC || bus.o_offset !== 32'd12)
            begin failures++; $display("FAIL bypass_issue: got valid=%b base=%h off=%h exp 1/abc/c", bus.o_valid, bus.o_base_addr, bus.o_offset); end
        step();
        checks++; if (bus.o_valid !== 1'b0) begin failures++; $display("FAIL bypass_drained: got %b exp 0", bus.o_valid); end
    endtask

    task automatic test_reset_mid();
        bus.i_lsu_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_disp(1'b1, 7'd1, 1'b1, 32'h900 + i, 7'd2, 1'b1, 32'h55, 32'h4, 4'(i + 3), 7'(i));
            step();
        end
        bus.i_disp_valid = 1'b0;
        #1;
        checks++; if (bus.o_valid !== 1'b1 || bus.o_base_addr !== 32'h900)
            begin failures++; $display("FAIL pre_reset_head: got valid=%b base=%h exp 1/900", bus.o_valid, bus.o_base_addr); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        checks++; if (bus.o_valid !== 1'b0 || bus.o_disp_ready !== 1'b1)
            begin failures++; $display("FAIL midreset_ctrl: got valid=%b ready=%b exp 0/1", bus.o_valid, bus.o_disp_ready); end
        checks++; if (bus.o_base_addr !== 32'h0 || bus.o_rob_tag !== 4'h0 || bus.o_memwrite !== 1'b0)
            begin failures++; $display("FAIL midreset_data: got base=%h rob=%0d mw=%b exp 0/0/0", bus.o_base_addr, bus.o_rob_tag, bus.o_memwrite); end
    endtask

    initial begin
        test_reset();
        test_load_issue();
        test_store_wakeup();
        test_full_wrap();
        test_in_order();
        test_flush();
        test_flush_wrap();
        test_disp_bypass();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ls_issue_queue.md
# ls_issue_queue

In-order issue queue for memory operations, sitting between rename/dispatch and `lsu_unit`. It buffers up to DEPTH loads and stores in program order and captures source operand values from the CDB. It presents the oldest operation to the LSU once that operation's operands are ready, and squashes entries younger than a mispredicted branch.

## Interface

Parameters:
- DATA_WIDTH, 32, operand/data width
- ROB_WIDTH, 4, ROB tag width
- PREG_WIDTH, 7, physical register tag width
- DEPTH, 8, queue entries (power of two, ≥2)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- i_disp_valid  in  1  dispatch request
- o_disp_ready  out  1  queue can accept an entry this cycle
- i_disp_memwrite  in  1  1 = store, 0 = load
- i_disp_alu_op  in  4  funct3 in [2:0], passed through
- i_disp_imm  in  DATA_WIDTH  sign-extended offset
- i_disp_prs1 / i_disp_prs2  in  PREG_WIDTH  source tags (base / store data)
- i_disp_rs1_rdy / i_disp_rs2_rdy  in  1  source value valid at dispatch
- i_disp_rs1_val / i_disp_rs2_val  in  DATA_WIDTH  source values when ready
- i_disp_prd  in  PREG_WIDTH  load destination
- i_disp_rob_tag  in  ROB_WIDTH  ROB tag
- i_cdb_valid  in  1  CDB broadcast valid
- i_cdb_prd  in  PREG_WIDTH  broadcast tag
- i_cdb_data  in  DATA_WIDTH  broadcast value
- o_valid  out  1  head operation ready to issue
- i_lsu_ready  in  1  LSU accepts (its o_ready)
- o_base_addr, o_offset, o_store_data  out  DATA_WIDTH  head rs1 value, imm, rs2 value
- o_memwrite  out  1
- o_alu_op  out  4
- o_prd  out  PREG_WIDTH
- o_rob_tag  out  ROB_WIDTH
- branch_mispredict  in  1  flush request
- branch_rob_tag  in  ROB_WIDTH  mispredicted branch tag

## Operation

- Storage is a circular buffer with head/tail pointers of log2(DEPTH) bits and a count of log2(DEPTH)+1 bits. Entries are kept in program order.
- Dispatch fires when i_disp_valid && o_disp_ready. The entry is written at the tail; tail increments modulo DEPTH.
- o_disp_ready = (count < DEPTH). Same-cycle issue does not free a slot for dispatch.
- rs2 is required only for stores; a load's rs2 is forced ready at dispatch.
- Wakeup: on i_cdb_valid, every valid entry with a not-ready source whose tag equals i_cdb_prd captures i_cdb_data and sets its ready bit.
- Dispatch-cycle bypass: an incoming source that is not ready but whose tag matches the CDB broadcast in the same cycle is written as ready with i_cdb_data.
- Issue is strictly in order.
  - o_valid = count≠0 && head rs1 ready && head rs2 ready, suppressed when branch_mispredict && head is younger than branch_rob_tag.
  - Issue fires when o_valid && i_lsu_ready. Head advances and count decrements on the next edge.
  - All o_* data outputs are driven from the head entry regardless of o_valid.
- Age rule: entry X is younger than branch B iff d = X.rob_tag − B (mod 2^ROB_WIDTH) satisfies d≠0 && d < 2^(ROB_WIDTH−1).
- Flush: on branch_mispredict, all entries younger than branch_rob_tag are removed. They are contiguous at the tail, so tail rewinds to the first younger entry and count is recomputed.
  - A dispatch in the same cycle is discarded.
  - An issue of an older head in the same cycle still completes.

## Timing

- Reset values: count=0, head=tail=0, all entries cleared to zero. Outputs: o_valid=0, o_disp_ready=1, all data/tag outputs 0.
- Minimum dispatch-to-issue latency is 1 cycle: an entry dispatched with both sources ready at edge N drives o_valid in cycle N+1.
- CDB wakeup at edge N makes the entry issuable in cycle N+1. There is no same-cycle CDB-to-issue path.
- Throughput: one dispatch and one issue per cycle.
- Full: dispatch is refused. If an issue happens that cycle, o_disp_ready rises in the next cycle.
- Empty: o_valid=0, and an entry dispatched this cycle is not visible this cycle.
- Wrap-around: pointers wrap at DEPTH, and count distinguishes full from empty.
- Flush and wakeup in the same cycle: surviving entries still capture the CDB value.
- Reset asserted mid-operation: all state clears on that edge, and pending entries are lost.

## Structure

- Shared package `ooo_pkg`:
  - `lsiq_entry_t` (valid, memwrite, alu_op, imm, prs1/2, rdy1/2, val1/2, prd, rob_tag)
  - the `is_younger(tag, ref)` function, also used by `lsu_unit` flush logic.
- One sub-module: `lsiq_wakeup`, a per-entry, purely combinational source-capture compare (tag match, ready/value update), instantiated twice per entry.

## Test plan

- Dispatch load (rs1 ready, val 0x100, imm 4, rob 3, lsu_ready=1) -> o_valid=1 next cycle with base 0x100, offset 4, memwrite 0, rob_tag 3; queue empty after the issue edge.
- Store with rs2 not ready (prs2=9); CDB prd 9, data 0xDEADBEEF two cycles later -> o_valid=0 until the cycle after the broadcast, then o_store_data=0xDEADBEEF.
- Fill 8 entries with i_lsu_ready=0 -> o_disp_ready=0 after the 8th. One issue -> o_disp_ready=1 the following cycle; tail wraps to slot 0.
- Head not ready, second entry ready -> o_valid stays 0 (no out-of-order issue) until the head's CDB wakeup.
- Entries rob 5,6,7,8; mispredict branch_rob_tag 6 -> only 5,6 remain, count 2. Entries rob 14,15,0; mispredict tag 15 -> 0 removed (wrap age check).
- Dispatch with CDB tag match in the same cycle -> entry ready immediately, issues the next cycle. Reset asserted with 3 entries -> o_valid=0, o_disp_ready=1 on the next cycle.
